e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage, beside the E-stage ALU.
- Executes mult/multu/div/divu with a fixed latency.
- Owns the architectural HI/LO registers and serves mthi/mtlo/mfhi/mflo.
- Drives a busy flag; hazard control uses it to stall D-stage MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- E_data1  input  32  rs operand.
- E_data2  input  32  rt operand.
- E_md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU; other codes = NONE.
- E_start  input  1  high for one cycle when a mult/div-class op is in E.
- E_busy  output  1  unit computing; HI/LO not yet updated.
- E_md_out  output  32  HI when op=MFHI, LO when op=MFLO, else 0.

Behaviour:
- Reset (async, any time incl. mid-operation): HI=0, LO=0, busy=0, counter=0, pending result discarded.
- Start acceptance: E_start=1, busy=0 and op in {MULT, MULTU, DIV, DIVU, MADD, MADDU} at edge t.
  - Operands and op latch at t; result computed into shadow registers.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES).
- Timing: busy=1 for exactly N cycles after t. At the edge where the counter reaches 0:
  - HI/LO take the result.
  - busy falls in the same cycle, so new HI/LO are visible with busy=0.
- Ignored starts:
  - E_start with a non-mult/div op.
  - E_start while busy=1 (no restart, no queueing). Hazard logic guarantees this never happens; the behaviour is still defined.
- MTHI/MTLO:
  - When busy=0: write E_data1 into HI/LO at the edge, no latency.
  - When busy=1: ignored.
- MFHI/MFLO: combinational from current HI/LO, so they show old values while busy.
- FSM:
  - IDLE -> RUN on an accepted start.
  - RUN stays while counter>1.
  - RUN -> IDLE on counter==1 edge, committing HI/LO.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 32x32 -> 64; same HI/LO split.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: busy sequence runs normally; HI/LO unchanged at commit.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MADD and MADDU are accepted.
  - {HI,LO} <= {HI,LO} + product (signed/unsigned product), 64-bit wrap-around, MULT_CYCLES latency.
  - The accumulate uses HI/LO as of the start edge.
- Undefined: codes 9/10 decode as NONE; no start, no stall.

Decomposition:
- Shared package/header `mdu_defs`:
  - md_op code constants (MD_NONE..MD_MADDU).
  - Default latencies, alongside the existing ALU op defines.
- One natural sub-module: `mdu_ctrl`, the IDLE/RUN FSM plus down-counter producing busy and commit.
- The datapath (multiply/divide/accumulate) stays in e_mdu.

Test Plan:
- Reset then MFHI/MFLO -> E_md_out=0 for both; assert reset mid-RUN at cycle 2 of a DIV -> busy drops immediately, HI=LO=0.
- MULT 0xFFFFFFFE x 0x00000003, start at t -> busy high t+1..t+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 / 2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 with HI=0x11, LO=0x22 -> unchanged after 10 cycles.
- MTHI 0xDEADBEEF while idle -> next cycle MFHI gives 0xDEADBEEF; MTLO and a second start issued during busy -> ignored, the original result commits on schedule.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1x1 -> HI=1, LO=0 after 5 cycles. Without the macro: op 9 with E_start=1 -> busy stays 0.

Source files
------------

// File: rtl/mdu_defs_pkg.sv
// Shared MDU definitions: md_op codes, default latencies, controller state.
// MDU_MADD_EN (when defined) makes MADD/MADDU startable operations.
package mdu_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_e;

  // Ops that launch a multi-cycle computation; MADD/MADDU only when enabled.
  function automatic logic is_start_op(input logic [3:0] op);
    logic ok;
    ok = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    ok = ok || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return ok;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// IDLE/RUN sequencer for the MDU: loads a cycle count on start, counts down,
// and flags the commit cycle. The state is exported so busy derives from it.
module mdu_ctrl
  import mdu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [3:0]  cycles_i,
  output ctrl_state_e state_o,
  output logic        commit_o
);

  ctrl_state_e state_q;
  logic [3:0]  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        CTRL_IDLE: begin
          if (start_i) begin
            state_q <= CTRL_RUN;
            cnt_q   <= cycles_i;
          end
        end
        CTRL_RUN: begin
          if (cnt_q <= 4'd1) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= CTRL_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign state_o  = state_q;
  assign commit_o = (state_q == CTRL_RUN) && (cnt_q <= 4'd1);

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div with busy.
// Build with MDU_MADD_EN defined to enable MADD/MADDU accumulation.
module e_mdu
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_data1,
  input  logic [31:0] E_data2,
  input  logic [3:0]  E_md_op,
  input  logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_md_out
);

  ctrl_state_e ctrl_state;
  logic        commit;
  logic        accept;
  logic [3:0]  cycles;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res_q, res_d;
  logic        res_wr_q, res_wr_d;

  assign E_busy = (ctrl_state == CTRL_RUN);
  assign accept = E_start && !E_busy && is_start_op(E_md_op);
  assign cycles = is_div_op(E_md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  mdu_ctrl u_ctrl (
    .clk      (clk),
    .rst      (reset),
    .start_i  (accept),
    .cycles_i (cycles),
    .state_o  (ctrl_state),
    .commit_o (commit)
  );

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_u, r_u, quo, rem;

  // Full result is formed at the start edge from the live operands and held
  // in the shadow register until the controller reaches its commit cycle.
  always_comb begin
    prod_s   = {{32{E_data1[31]}}, E_data1} * {{32{E_data2[31]}}, E_data2};
    prod_u   = {32'd0, E_data1} * {32'd0, E_data2};
    a_neg    = (E_md_op == MD_DIV) && E_data1[31];
    b_neg    = (E_md_op == MD_DIV) && E_data2[31];
    a_mag    = a_neg ? -E_data1 : E_data1;
    b_mag    = b_neg ? -E_data2 : E_data2;
    b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_u      = a_mag / b_safe;
    r_u      = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? -q_u : q_u;
    rem      = a_neg ? -r_u : r_u;
    res_d    = 64'd0;
    res_wr_d = 1'b1;
    case (E_md_op)
      MD_MULT:  res_d = prod_s;
      MD_MULTU: res_d = prod_u;
      MD_DIV, MD_DIVU: begin
        res_d    = {rem, quo};
        res_wr_d = (E_data2 != 32'd0);
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res_d = {hi_q, lo_q} + prod_s;
      MD_MADDU: res_d = {hi_q, lo_q} + prod_u;
`endif
      default: begin
        res_d    = 64'd0;
        res_wr_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (res_wr_q) begin
        hi_d = res_q[63:32];
        lo_d = res_q[31:0];
      end
    end else if (!E_busy) begin
      if (E_md_op == MD_MTHI) hi_d = E_data1;
      if (E_md_op == MD_MTLO) lo_d = E_data1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_q    <= 64'd0;
      res_wr_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (accept) begin
        res_q    <= res_d;
        res_wr_q <= res_wr_d;
      end
    end
  end

  assign E_md_out = (E_md_op == MD_MFHI) ? hi_q :
                    (E_md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed + randomized bench for e_mdu against a longint-arithmetic HI/LO model.
module tb_e_mdu;
  import mdu_defs::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_data1, E_data2;
  logic [3:0]  E_md_op;
  logic        E_start;
  logic        E_busy;
  logic [31:0] E_md_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_data1  (E_data1),
    .E_data2  (E_data2),
    .E_md_op  (E_md_op),
    .E_start  (E_start),
    .E_busy   (E_busy),
    .E_md_out (E_md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of one accepted op on the model HI/LO.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      MD_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      MD_MADD:  begin p = 64'(sa * sb); acc = {m_hi, m_lo} + p; {m_hi, m_lo} = acc; end
      MD_MADDU: begin p = {32'd0, a} * {32'd0, b}; acc = {m_hi, m_lo} + p; {m_hi, m_lo} = acc; end
      default: ;
    endcase
  endtask

  task automatic read_hilo(input string tag);
    E_md_op = MD_MFHI; #1;
    check({tag, "_hi"}, E_md_out, m_hi);
    E_md_op = MD_MFLO; #1;
    check({tag, "_lo"}, E_md_out, m_lo);
    E_md_op = MD_NONE; #1;
    check({tag, "_none0"}, E_md_out, 32'd0);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    E_md_op = op; E_data1 = v;
    @(negedge clk);
    E_md_op = MD_NONE;
    if (op == MD_MTHI) m_hi = v;
    else m_lo = v;
  endtask

  // Called at a negedge; returns at a negedge after busy has dropped.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere);
    int n;
    n = (op == MD_DIV || op == MD_DIVU) ? DIV_N : MULT_N;
    E_md_op = op; E_data1 = a; E_data2 = b; E_start = 1'b1;
    @(negedge clk);
    E_start = 1'b0; E_md_op = MD_NONE;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, E_busy}, 32'd1);
      if (interfere) begin
        if (i == 0) begin
          E_md_op = MD_MFHI; #1;
          check({tag, "_stale_hi"}, E_md_out, m_hi);
        end
        if (i == 1) begin E_md_op = MD_MTLO; E_data1 = 32'hBAD0BAD0; end
        if (i == 2) begin E_md_op = MD_DIV; E_data1 = 32'd100; E_data2 = 32'd7; E_start = 1'b1; end
        if (i == 3) begin E_md_op = MD_NONE; E_start = 1'b0; end
      end
      @(negedge clk);
    end
    check({tag, "_idle"}, {31'd0, E_busy}, 32'd0);
    model_apply(op, a, b);
    read_hilo(tag);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; E_data1 = '0; E_data2 = '0; E_md_op = MD_NONE; E_start = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, E_busy}, 32'd0);
    read_hilo("rst");

    run_md("mult", MD_MULT, 32'hFFFFFFFE, 32'h00000003, 1'b0);
    check("mult_hi_const", m_hi, 32'hFFFFFFFF);
    check("mult_lo_const", m_lo, 32'hFFFFFFFA);
    run_md("multu", MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 1'b0);
    run_md("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_const", m_lo, 32'hFFFFFFFD);

    move_to(MD_MTHI, 32'h11);
    move_to(MD_MTLO, 32'h22);
    run_md("divu0", MD_DIVU, 32'd7, 32'd0, 1'b0);
    move_to(MD_MTHI, 32'hDEADBEEF);
    read_hilo("mthi");
    run_md("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_md("intf", MD_MULT, 32'h12345678, 32'h9ABCDEF0, 1'b1);

    for (int k = 0; k < 24; k++) begin
`ifdef MDU_MADD_EN
      rop = 4'($urandom_range(0, 5));
      rop = (rop > 4'd3) ? rop + 4'd5 : rop + 4'd1;
`else
      rop = 4'($urandom_range(1, 4));
`endif
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_md("rnd", rop, ra, rb, 1'b0);
    end

`ifdef MDU_MADD_EN
    move_to(MD_MTHI, 32'd0);
    move_to(MD_MTLO, 32'hFFFFFFFF);
    run_md("maddu", MD_MADDU, 32'd1, 32'd1, 1'b0);
    check("maddu_hi_const", m_hi, 32'd1);
`else
    E_md_op = MD_MADD; E_data1 = 32'd3; E_data2 = 32'd4; E_start = 1'b1;
    @(negedge clk);
    E_start = 1'b0; E_md_op = MD_NONE;
    for (int i = 0; i < 3; i++) begin
      check("madd_off_busy", {31'd0, E_busy}, 32'd0);
      @(negedge clk);
    end
    read_hilo("madd_off");
`endif

    E_md_op = MD_DIV; E_data1 = 32'd50; E_data2 = 32'd3; E_start = 1'b1;
    @(negedge clk);
    E_start = 1'b0; E_md_op = MD_NONE;
    @(negedge clk);
    check("midrst_busy_pre", {31'd0, E_busy}, 32'd1);
    reset = 1'b1; #1;
    check("midrst_busy", {31'd0, E_busy}, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (DIV_N) @(negedge clk);
    check("midrst_still_idle", {31'd0, E_busy}, 32'd0);
    read_hilo("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
